// File: rtl/full_adder.sv
// One-bit full adder with combinational sum/carry, an enabled registered
// copy of the result and a saturating counter of enabled carry cycles.
module full_adder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             en,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] carry_cnt
);

    // All-ones is the saturation ceiling; the counter never wraps past it.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Sum bit is the odd parity of the three inputs.
    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        fa_sum = x ^ y ^ z;
    endfunction

    // Carry-out is the majority of the three inputs.
    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        fa_carry = (x & y) | (x & z) | (y & z);
    endfunction

    logic             sum_s;
    logic             carry_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             sum_r;
    logic             carry_r;
    logic             valid_r;
    logic [CNT_W-1:0] cnt_r;

    // Zero-latency adder result; deliberately independent of clk, rst and en.
    always_comb begin
        sum_s   = fa_sum(a, b, cin);
        carry_s = fa_carry(a, b, cin);
    end

    // Next counter value: count enabled carry cycles, stick at all-ones.
    always_comb begin
        cnt_next_s = cnt_r;
        if (en && carry_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Capture registers: reset wins over enable, en=0 holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r   <= 1'b0;
            carry_r <= 1'b0;
            valid_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (en) begin
            sum_r   <= sum_s;
            carry_r <= carry_s;
            valid_r <= 1'b1;
            cnt_r   <= cnt_next_s;
        end else begin
            sum_r   <= sum_r;
            carry_r <= carry_r;
            valid_r <= valid_r;
            cnt_r   <= cnt_r;
        end
    end

    assign sum       = sum_s;
    assign carry     = carry_s;
    assign sum_q     = sum_r;
    assign carry_q   = carry_r;
    assign valid_q   = valid_r;
    assign carry_cnt = cnt_r;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder (CNT_W=2 so saturation is reachable).
module tb_full_adder;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             a;
    logic             b;
    logic             cin;
    logic             en;
    logic             sum;
    logic             carry;
    logic             sum_q;
    logic             carry_q;
    logic             valid_q;
    logic [CNT_W-1:0] carry_cnt;

    full_adder #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .en       (en),
        .sum      (sum),
        .carry    (carry),
        .sum_q    (sum_q),
        .carry_q  (carry_q),
        .valid_q  (valid_q),
        .carry_cnt(carry_cnt)
    );

    typedef struct {
        string            name;
        bit               chk_comb;
        logic             es;
        logic             ec;
        bit               chk_reg;
        logic             esq;
        logic             ecq;
        logic             ev;
        logic [CNT_W-1:0] ecnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    // 10 ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: at each falling edge, pop and compare every pending expectation.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_popped++;
            if (e.chk_comb) begin
                cmp({e.name, ".sum"},   {1'b0, sum},   {1'b0, e.es});
                cmp({e.name, ".carry"}, {1'b0, carry}, {1'b0, e.ec});
            end
            if (e.chk_reg) begin
                cmp({e.name, ".sum_q"},     {1'b0, sum_q},   {1'b0, e.esq});
                cmp({e.name, ".carry_q"},   {1'b0, carry_q}, {1'b0, e.ecq});
                cmp({e.name, ".valid_q"},   {1'b0, valid_q}, {1'b0, e.ev});
                cmp({e.name, ".carry_cnt"}, carry_cnt,       e.ecnt);
            end
        end
    end

    // One cycle: drive inputs just after the rising edge and push what the
    // monitor must see at the following falling edge. Register expectations
    // describe the state left by the edge that started this cycle.
    task automatic cyc(input string nm, input logic [2:0] abc, input logic ie, input logic ir,
                       input bit cc, input logic es, input logic ec,
                       input bit cr, input logic esq, input logic ecq, input logic ev,
                       input logic [CNT_W-1:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        a   = abc[2];
        b   = abc[1];
        cin = abc[0];
        en  = ie;
        rst = ir;
        e.name = nm; e.chk_comb = cc; e.es = es; e.ec = ec;
        e.chk_reg = cr; e.esq = esq; e.ecq = ecq; e.ev = ev; e.ecnt = ecnt;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        logic [1:0] truth [8];
        truth[0] = 2'b00; truth[1] = 2'b01; truth[2] = 2'b01; truth[3] = 2'b10;
        truth[4] = 2'b01; truth[5] = 2'b10; truth[6] = 2'b10; truth[7] = 2'b11;

        a = 1'b0; b = 1'b0; cin = 1'b0; en = 1'b0; rst = 1'b1;

        // reset
        cyc("rst0", 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        cyc("rst1", 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // exhaustive combinational sweep, registers stay cleared (en=0)
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            cyc($sformatf("sweep%0d", i), v, 1'b0, 1'b0,
                1'b1, truth[i][0], truth[i][1],
                1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        end

        // registered latency: 110 captured one edge later
        cyc("lat_drive", 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        cyc("lat_cap",   3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1);

        // enable hold: 001 captured, then 110 with en=0 for three edges
        cyc("hold_cap", 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        cyc("hold1",    3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        cyc("hold2",    3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        cyc("hold3",    3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);

        // saturation: 111 with en=1 for five edges -> 1,2,3,3,3
        cyc("sat_rst", 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        cyc("sat1",    3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
        cyc("sat2",    3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
        cyc("sat3",    3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
        cyc("sat4",    3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);

        // reset priority at saturation, combinational outputs unaffected
        cyc("rstpri",  3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
        cyc("rstdone", 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // resume from zero after reset
        cyc("resume",  3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        cyc("resumed", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1);

        // let the monitor drain, bounded
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (n_popped != n_pushed) begin
            n_fail++;
            $display("FAIL drain: monitor consumed %0d, expected %0d", n_popped, n_pushed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event counter; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high; sampled only on rising clk edge.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 cin  input  1  carry-in bit.
REQ-007 en  input  1  register-update enable for registered outputs and counter.
REQ-008 sum  output  1  combinational sum bit, a XOR b XOR cin.
REQ-009 carry  output  1  combinational carry-out, majority(a, b, cin).
REQ-010 sum_q  output  1  registered copy of sum.
REQ-011 carry_q  output  1  registered copy of carry.
REQ-012 valid_q  output  1  high when sum_q/carry_q hold a result captured under en.
REQ-013 carry_cnt  output  CNT_W  saturating count of enabled cycles with carry=1.

Function
REQ-014 sum and carry SHALL be purely combinational, zero latency, independent of clk, rst and en.
REQ-015 Truth table for {a,b,cin} -> {carry,sum}: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
REQ-016 sum and carry SHALL settle within the same simulation time step as an input change; no glitch-dependent behaviour is specified.
REQ-017 On a rising edge with rst=0 and en=1: sum_q<=sum, carry_q<=carry, valid_q<=1 (latency one cycle).
REQ-018 On a rising edge with rst=0 and en=0: sum_q, carry_q, valid_q and carry_cnt SHALL hold their values.
REQ-019 On a rising edge with rst=0, en=1, carry=1: carry_cnt SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-020 On a rising edge with rst=0, en=1, carry=0: carry_cnt SHALL hold.
REQ-021 At saturation, further qualifying cycles SHALL leave carry_cnt at all-ones.
REQ-022 Registered outputs SHALL use the combinational sum/carry values present immediately before the clock edge.

Reset
REQ-023 rst=1 at a rising edge SHALL force sum_q=0, carry_q=0, valid_q=0, carry_cnt=0, overriding en.
REQ-024 rst SHALL NOT affect sum or carry; combinational outputs remain valid during reset.
REQ-025 Reset asserted mid-operation (including at counter saturation) SHALL take effect at the next rising edge; the first edge with rst=0 and en=1 resumes normal capture from zero.
REQ-026 Before the first reset, registered outputs are undefined; the bench SHALL apply rst for at least one edge.

Verification
REQ-027 Exhaustive sweep: apply all 8 {a,b,cin} combos in order 000..111, 10 ns each -> sum/carry match REQ-015 (e.g. 011 -> sum=0, carry=1; 111 -> sum=1, carry=1).
REQ-028 Registered latency: rst then en=1, drive 110 -> after next edge sum_q=0, carry_q=1, valid_q=1; combinational carry=1 immediately.
REQ-029 Enable hold: capture 001 (sum_q=1), set en=0, drive 110 for 3 edges -> sum_q stays 1, carry_q stays 0, carry_cnt unchanged.
REQ-030 Counter saturation (CNT_W=2): en=1, drive 111 for 5 edges -> carry_cnt = 1,2,3,3,3.
REQ-031 Reset priority: with carry_cnt=3, assert rst=1, en=1, inputs 111 for one edge -> carry_cnt=0, sum_q=0, carry_q=0, valid_q=0, while sum=1, carry=1.
